// File: rtl/corr_seq_pkg.sv
// Shared constants and state encoding for the correlator job sequencer.
package corr_seq_pkg;

  localparam int unsigned CNT_W             = 32;
  localparam logic [31:0] CTRL_ADDR_DEFAULT = 32'h10;
  localparam logic [1:0]  BRESP_OKAY        = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_RESP   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/corr_job_sequencer.sv
// Runs one correlator job: programs the kernel element count over AXI-lite,
// then passes host beats to the kernel and kernel results back to the host.
module corr_job_sequencer
  import corr_seq_pkg::*;
#(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned DEST_W    = 4,
  parameter logic [31:0] CTRL_ADDR = CTRL_ADDR_DEFAULT
) (
  input  logic                ap_clk,
  input  logic                ap_rst,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CNT_W-1:0]    cmd_elements,

  output logic                done_valid,
  input  logic                done_ready,
  output logic [CNT_W-1:0]    done_results,
  output logic                done_err,

  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [4:0]          m_axil_awaddr,
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  output logic [31:0]         m_axil_wdata,
  output logic [3:0]          m_axil_wstrb,
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  input  logic [1:0]          m_axil_bresp,

  input  logic [DATA_W-1:0]   s_axis_in_tdata,
  input  logic [DATA_W/8-1:0] s_axis_in_tkeep,
  input  logic [DEST_W-1:0]   s_axis_in_tdest,
  input  logic                s_axis_in_tvalid,
  output logic                s_axis_in_tready,

  output logic [DATA_W-1:0]   m_axis_kin_tdata,
  output logic [DATA_W/8-1:0] m_axis_kin_tkeep,
  output logic [DEST_W-1:0]   m_axis_kin_tdest,
  output logic                m_axis_kin_tlast,
  output logic                m_axis_kin_tvalid,
  input  logic                m_axis_kin_tready,

  input  logic [DATA_W-1:0]   s_axis_kout_tdata,
  input  logic [DATA_W/8-1:0] s_axis_kout_tkeep,
  input  logic [DEST_W-1:0]   s_axis_kout_tdest,
  input  logic                s_axis_kout_tlast,
  input  logic                s_axis_kout_tvalid,
  output logic                s_axis_kout_tready,

  output logic [DATA_W-1:0]   m_axis_out_tdata,
  output logic [DATA_W/8-1:0] m_axis_out_tkeep,
  output logic [DEST_W-1:0]   m_axis_out_tdest,
  output logic                m_axis_out_tlast,
  output logic                m_axis_out_tvalid,
  input  logic                m_axis_out_tready
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic               err_q, err_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               last_seen_q, last_seen_d;

  logic               in_fire;
  logic               kout_fire;
  logic               kout_end;
  logic               in_last;
  logic               aw_ok;
  logic               w_ok;

  // Handshakes as they would complete while the pass-through is open.
  assign in_fire   = s_axis_in_tvalid & m_axis_kin_tready;
  assign kout_fire = s_axis_kout_tvalid & m_axis_out_tready;
  assign kout_end  = kout_fire & s_axis_kout_tlast;
  assign in_last   = (in_cnt_q == count_q - CNT_W'(1));

  // Payload wires are routed straight through; only valid/ready are gated.
  assign m_axis_kin_tdata = s_axis_in_tdata;
  assign m_axis_kin_tkeep = s_axis_in_tkeep;
  assign m_axis_kin_tdest = s_axis_in_tdest;
  assign m_axis_out_tdata = s_axis_kout_tdata;
  assign m_axis_out_tkeep = s_axis_kout_tkeep;
  assign m_axis_out_tdest = s_axis_kout_tdest;

  assign m_axil_awaddr = CTRL_ADDR[4:0];
  assign m_axil_wdata  = count_q;
  assign m_axil_wstrb  = 4'hF;
  assign done_results  = res_cnt_q;
  assign done_err      = err_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      in_cnt_q    <= '0;
      res_cnt_q   <= '0;
      err_q       <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_cnt_q    <= in_cnt_d;
      res_cnt_q   <= res_cnt_d;
      err_q       <= err_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      last_seen_q <= last_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    in_cnt_d    = in_cnt_q;
    res_cnt_d   = res_cnt_q;
    err_d       = err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    last_seen_d = last_seen_q;
    aw_ok       = 1'b0;
    w_ok        = 1'b0;

    cmd_ready          = 1'b0;
    done_valid         = 1'b0;
    m_axil_awvalid     = 1'b0;
    m_axil_wvalid      = 1'b0;
    m_axil_bready      = 1'b0;
    s_axis_in_tready   = 1'b0;
    m_axis_kin_tvalid  = 1'b0;
    m_axis_kin_tlast   = 1'b0;
    s_axis_kout_tready = 1'b0;
    m_axis_out_tvalid  = 1'b0;
    m_axis_out_tlast   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          in_cnt_d  = '0;
          res_cnt_d = '0;
          if (cmd_elements == '0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            count_d     = cmd_elements;
            err_d       = 1'b0;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            last_seen_d = 1'b0;
            state_d     = ST_CFG;
          end
        end
      end

      // AW and W channels complete independently, in either order.
      ST_CFG: begin
        m_axil_awvalid = ~aw_done_q;
        m_axil_wvalid  = ~w_done_q;
        aw_ok          = aw_done_q | m_axil_awready;
        w_ok           = w_done_q | m_axil_wready;
        aw_done_d      = aw_ok;
        w_done_d       = w_ok;
        if (aw_ok && w_ok) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        m_axil_bready = 1'b1;
        if (m_axil_bvalid) begin
          if (m_axil_bresp == BRESP_OKAY) begin
            state_d = ST_STREAM;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_STREAM: begin
        s_axis_in_tready   = m_axis_kin_tready;
        m_axis_kin_tvalid  = s_axis_in_tvalid;
        m_axis_kin_tlast   = in_last;
        s_axis_kout_tready = m_axis_out_tready;
        m_axis_out_tvalid  = s_axis_kout_tvalid;
        m_axis_out_tlast   = s_axis_kout_tlast;
        if (kout_fire) begin
          res_cnt_d = res_cnt_q + CNT_W'(1);
        end
        if (kout_end) begin
          last_seen_d = 1'b1;
        end
        // A result tlast already seen means there is nothing left to drain.
        if (in_fire) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_last) begin
            state_d = (last_seen_q || kout_end) ? ST_DONE : ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        s_axis_kout_tready = m_axis_out_tready;
        m_axis_out_tvalid  = s_axis_kout_tvalid;
        m_axis_out_tlast   = s_axis_kout_tlast;
        if (kout_fire) begin
          res_cnt_d = res_cnt_q + CNT_W'(1);
        end
        if (kout_end) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_corr_job_sequencer.sv
// Self-checking bench: table-driven jobs, randomized jobs against a job-level
// reference model, and a mid-job reset sequence.
module tb_corr_job_sequencer;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned TW = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          cmd_valid, cmd_ready;
  logic [31:0]   cmd_elements;
  logic          done_valid, done_ready, done_err;
  logic [31:0]   done_results;
  logic          m_axil_awvalid, m_axil_awready;
  logic [4:0]    m_axil_awaddr;
  logic          m_axil_wvalid, m_axil_wready;
  logic [31:0]   m_axil_wdata;
  logic [3:0]    m_axil_wstrb;
  logic          m_axil_bvalid, m_axil_bready;
  logic [1:0]    m_axil_bresp;
  logic [DW-1:0] s_axis_in_tdata, m_axis_kin_tdata, s_axis_kout_tdata, m_axis_out_tdata;
  logic [KW-1:0] s_axis_in_tkeep, m_axis_kin_tkeep, s_axis_kout_tkeep, m_axis_out_tkeep;
  logic [TW-1:0] s_axis_in_tdest, m_axis_kin_tdest, s_axis_kout_tdest, m_axis_out_tdest;
  logic          s_axis_in_tvalid, s_axis_in_tready;
  logic          m_axis_kin_tlast, m_axis_kin_tvalid, m_axis_kin_tready;
  logic          s_axis_kout_tlast, s_axis_kout_tvalid, s_axis_kout_tready;
  logic          m_axis_out_tlast, m_axis_out_tvalid, m_axis_out_tready;

  always #5 ap_clk = ~ap_clk;

  corr_job_sequencer #(.DATA_W(DW), .DEST_W(TW), .CTRL_ADDR(32'h10)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_elements(cmd_elements),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_results(done_results), .done_err(done_err),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready), .m_axil_awaddr(m_axil_awaddr),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_bresp(m_axil_bresp),
    .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tkeep(s_axis_in_tkeep),
    .s_axis_in_tdest(s_axis_in_tdest), .s_axis_in_tvalid(s_axis_in_tvalid),
    .s_axis_in_tready(s_axis_in_tready),
    .m_axis_kin_tdata(m_axis_kin_tdata), .m_axis_kin_tkeep(m_axis_kin_tkeep),
    .m_axis_kin_tdest(m_axis_kin_tdest), .m_axis_kin_tlast(m_axis_kin_tlast),
    .m_axis_kin_tvalid(m_axis_kin_tvalid), .m_axis_kin_tready(m_axis_kin_tready),
    .s_axis_kout_tdata(s_axis_kout_tdata), .s_axis_kout_tkeep(s_axis_kout_tkeep),
    .s_axis_kout_tdest(s_axis_kout_tdest), .s_axis_kout_tlast(s_axis_kout_tlast),
    .s_axis_kout_tvalid(s_axis_kout_tvalid), .s_axis_kout_tready(s_axis_kout_tready),
    .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tkeep(m_axis_out_tkeep),
    .m_axis_out_tdest(m_axis_out_tdest), .m_axis_out_tlast(m_axis_out_tlast),
    .m_axis_out_tvalid(m_axis_out_tvalid), .m_axis_out_tready(m_axis_out_tready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         n;
    int         nres;
    int         aw_dly;
    int         w_dly;
    logic [1:0] bresp;
    int         extra;
    bit         rnd;
    int         rst_after;
    bit         exp_err;
    int         exp_res;
    int         exp_kin;
    int         exp_aw;
  } job_t;

  // Job-level outcome: what the host should see, ignoring cycle detail.
  function automatic job_t model(input job_t j);
    job_t r = j;
    if (j.n == 0) begin
      r.exp_err = 1'b1; r.exp_res = 0; r.exp_kin = 0; r.exp_aw = 0;
    end else if (j.bresp != 2'b00) begin
      r.exp_err = 1'b1; r.exp_res = 0; r.exp_kin = 0; r.exp_aw = 1;
    end else begin
      r.exp_err = 1'b0; r.exp_res = j.nres; r.exp_kin = j.n; r.exp_aw = 1;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_elements = '0; done_ready = 1'b0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
    s_axis_in_tdata = '0; s_axis_in_tkeep = '0; s_axis_in_tdest = '0; s_axis_in_tvalid = 1'b0;
    m_axis_kin_tready = 1'b0;
    s_axis_kout_tdata = '0; s_axis_kout_tkeep = '0; s_axis_kout_tdest = '0;
    s_axis_kout_tlast = 1'b0; s_axis_kout_tvalid = 1'b0;
    m_axis_out_tready = 1'b0;
  endtask

  task automatic chk_quiet_idle(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_done_valid"}, 64'(done_valid), 64'd0);
    chk({tag, "_axil"}, 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'd0);
    chk({tag, "_streams"}, 64'({m_axis_kin_tvalid, s_axis_in_tready,
                                m_axis_out_tvalid, s_axis_kout_tready}), 64'd0);
  endtask

  task automatic run_job(input job_t j, input string tag);
    logic [DW-1:0] hq[$];
    logic [DW-1:0] rq[$];
    logic [DW-1:0] exp_d;
    logic [31:0]   d_res;
    logic          d_err;
    int hi = 0, ki = 0, cyc = 0, done_seen = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, aw_wait = 0, w_wait = 0;
    int aw_cyc = 0, w_cyc = 0, cmd_cyc = 0, done_cyc = 0;
    bit cmd_sent = 0, fin = 0, busy_bad = 0, quiet_bad = 0, tie_bad = 0;
    d_res = '0;
    d_err = 1'b0;
    for (int i = 0; i < j.n + j.extra; i++) hq.push_back({$urandom, $urandom});
    for (int i = 0; i < j.nres; i++) rq.push_back({$urandom, $urandom});

    while (!fin && cyc < 3000) begin
      @(negedge ap_clk);
      cmd_valid          = !cmd_sent;
      cmd_elements       = 32'(j.n);
      m_axil_awready     = (aw_wait >= j.aw_dly);
      m_axil_wready      = (w_wait >= j.w_dly);
      m_axil_bvalid      = (aw_hs > 0 && w_hs > 0 && b_hs == 0);
      m_axil_bresp       = j.bresp;
      s_axis_in_tvalid   = (hi < hq.size()) && (!j.rnd || $urandom_range(3) != 0);
      s_axis_in_tdata    = (hi < hq.size()) ? hq[hi] : '0;
      s_axis_in_tkeep    = '1;
      s_axis_in_tdest    = TW'(hi);
      m_axis_kin_tready  = !j.rnd || $urandom_range(3) != 0;
      s_axis_kout_tvalid = (ki < rq.size()) && (!j.rnd || $urandom_range(2) != 0);
      s_axis_kout_tdata  = (ki < rq.size()) ? rq[ki] : '0;
      s_axis_kout_tlast  = (ki == rq.size() - 1);
      s_axis_kout_tkeep  = '1;
      s_axis_kout_tdest  = TW'(ki);
      m_axis_out_tready  = !j.rnd || $urandom_range(3) != 0;
      done_ready         = (done_seen >= 1);
      #1;
      if (cmd_sent && cmd_ready) busy_bad = 1;
      if ((cmd_ready || m_axil_awvalid || m_axil_wvalid || m_axil_bready || done_valid) &&
          (m_axis_kin_tvalid || s_axis_in_tready || m_axis_out_tvalid || s_axis_kout_tready))
        quiet_bad = 1;
      if ((s_axis_in_tvalid && s_axis_in_tready) != (m_axis_kin_tvalid && m_axis_kin_tready))
        tie_bad = 1;
      if ((s_axis_kout_tvalid && s_axis_kout_tready) != (m_axis_out_tvalid && m_axis_out_tready))
        tie_bad = 1;

      if (cmd_valid && cmd_ready) begin cmd_sent = 1; cmd_cyc = cyc; end
      if (m_axil_awvalid) begin
        if (m_axil_awready) begin
          aw_hs++; aw_cyc = cyc;
          chk({tag, "_awaddr"}, 64'(m_axil_awaddr), 64'h10);
        end else aw_wait++;
      end
      if (m_axil_wvalid) begin
        if (m_axil_wready) begin
          w_hs++; w_cyc = cyc;
          chk({tag, "_wdata"}, {28'd0, m_axil_wstrb, m_axil_wdata}, {28'd0, 4'hF, 32'(j.n)});
        end else w_wait++;
      end
      if (m_axil_bvalid && m_axil_bready) b_hs++;

      if (m_axis_kin_tvalid && m_axis_kin_tready) begin
        exp_d = (hi < hq.size()) ? hq[hi] : '0;
        chk({tag, "_kin_data"}, m_axis_kin_tdata, exp_d);
        chk({tag, "_kin_side"}, 64'({m_axis_kin_tkeep, m_axis_kin_tdest}), 64'({8'hFF, TW'(hi)}));
        chk({tag, "_kin_tlast"}, 64'(m_axis_kin_tlast), 64'(hi == j.n - 1));
        hi++;
        if (j.rst_after > 0 && hi == j.rst_after) fin = 1;
      end
      if (m_axis_out_tvalid && m_axis_out_tready) begin
        exp_d = (ki < rq.size()) ? rq[ki] : '0;
        chk({tag, "_out_data"}, m_axis_out_tdata, exp_d);
        chk({tag, "_out_side"}, 64'({m_axis_out_tkeep, m_axis_out_tdest, m_axis_out_tlast}),
            64'({8'hFF, TW'(ki), ki == j.nres - 1}));
        ki++;
      end
      if (done_valid) begin
        if (done_seen == 0) begin
          done_cyc = cyc; d_res = done_results; d_err = done_err;
          chk({tag, "_done_results"}, 64'(done_results), 64'(j.exp_res));
          chk({tag, "_done_err"}, 64'(done_err), 64'(j.exp_err));
        end else begin
          chk({tag, "_done_stable"}, 64'({done_err, done_results}), 64'({d_err, d_res}));
        end
        done_seen++;
        if (done_ready) fin = 1;
      end
      cyc++;
    end

    chk({tag, "_timeout"}, 64'(fin), 64'd1);
    if (j.rst_after > 0) begin
      @(negedge ap_clk);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      cmd_valid = 1'b0; done_ready = 1'b0;
      s_axis_in_tvalid = 1'b1; m_axis_kin_tready = 1'b1;
      s_axis_kout_tvalid = 1'b1; m_axis_out_tready = 1'b1;
      m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_bvalid = 1'b1;
      #1;
      chk_quiet_idle({tag, "_after_rst"});
      for (int i = 0; i < 3; i++) begin
        @(negedge ap_clk); #1;
        chk({tag, "_no_done_after_rst"}, 64'(done_valid), 64'd0);
      end
      @(negedge ap_clk);
      idle_inputs();
      return;
    end

    chk({tag, "_kin_beats"}, 64'(hi), 64'(j.exp_kin));
    chk({tag, "_out_beats"}, 64'(ki), 64'(j.exp_res));
    chk({tag, "_axil_hs"}, 64'({8'(aw_hs), 8'(w_hs), 8'(b_hs)}),
        64'({8'(j.exp_aw), 8'(j.exp_aw), 8'(j.exp_aw)}));
    if (j.exp_aw == 1) chk({tag, "_aw_w_skew"}, 64'(aw_cyc - w_cyc), 64'(j.aw_dly - j.w_dly));
    if (j.n == 0) chk({tag, "_zero_done_lat"}, 64'(done_cyc - cmd_cyc), 64'd1);
    chk({tag, "_busy_cmd_ready"}, 64'(busy_bad), 64'd0);
    chk({tag, "_stream_gating"}, 64'(quiet_bad), 64'd0);
    chk({tag, "_ready_tie"}, 64'(tie_bad), 64'd0);
    @(negedge ap_clk);
    idle_inputs();
    #1;
    chk_quiet_idle({tag, "_post"});
    chk({tag, "_err_cleared"}, 64'(done_err), 64'd0);
  endtask

  job_t vecs[8];
  job_t rj;

  initial begin
    // n, nres, aw_dly, w_dly, bresp, extra, rnd, rst_after, exp_err, exp_res, exp_kin, exp_aw
    vecs[0] = '{10, 10, 0, 0, 2'b00, 0, 1'b0, 0, 1'b0, 10, 10, 1};
    vecs[1] = '{10, 10, 3, 0, 2'b00, 0, 1'b0, 0, 1'b0, 10, 10, 1};
    vecs[2] = '{ 0,  3, 0, 0, 2'b00, 2, 1'b0, 0, 1'b1,  0,  0, 0};
    vecs[3] = '{ 6,  4, 0, 0, 2'b10, 3, 1'b0, 0, 1'b1,  0,  0, 1};
    vecs[4] = '{ 8,  5, 1, 2, 2'b00, 4, 1'b1, 0, 1'b0,  5,  8, 1};
    vecs[5] = '{ 1,  1, 0, 0, 2'b00, 1, 1'b0, 0, 1'b0,  1,  1, 1};
    vecs[6] = '{ 4,  1, 0, 2, 2'b00, 0, 1'b0, 0, 1'b0,  1,  4, 1};
    vecs[7] = '{10, 10, 0, 0, 2'b00, 0, 1'b0, 4, 1'b0,  0,  0, 0};

    idle_inputs();
    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    chk_quiet_idle("reset");
    chk("reset_done_fields", 64'({done_err, done_results}), 64'd0);

    for (int v = 0; v < 8; v++) run_job(vecs[v], $sformatf("vec%0d", v));

    for (int r = 0; r < 30; r++) begin
      rj.n         = int'($urandom_range(20));
      rj.nres      = int'($urandom_range(12, 1));
      rj.aw_dly    = int'($urandom_range(3));
      rj.w_dly     = int'($urandom_range(3));
      rj.bresp     = ($urandom_range(4) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      rj.extra     = int'($urandom_range(4));
      rj.rnd       = 1'b1;
      rj.rst_after = 0;
      rj = model(rj);
      run_job(rj, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/corr_job_sequencer.md
CORR_JOB_SEQUENCER -- requirements
Module: corr_job_sequencer

Interface
REQ-001 Parameter DATA_W, default 512, stream data width.
REQ-002 Parameter DEST_W, default 4, stream TDEST width.
REQ-003 Parameter CTRL_ADDR, default 32'h10, kernel element-count register address.
REQ-004 ap_clk  in  1  sole clock; all logic on rising edge.
REQ-005 ap_rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  job request handshake.
REQ-007 cmd_elements  in  32  input beats in the job.
REQ-008 done_valid/done_ready  out/in  1/1  job completion handshake.
REQ-009 done_results  out  32  result beats forwarded in the job.
REQ-010 done_err  out  1  job aborted (zero count or BRESP != OKAY).
REQ-011 m_axil_awvalid/awready/awaddr  out/in/out  1/1/5  kernel control write address.
REQ-012 m_axil_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  kernel control write data.
REQ-013 m_axil_bvalid/bready/bresp  in/out/in  1/1/2  kernel control write response.
REQ-014 s_axis_in_tdata/tkeep/tdest/tvalid/tready  in x4/out  DATA_W/DATA_W/8/DEST_W/1/1  host input stream.
REQ-015 m_axis_kin_tdata/tkeep/tdest/tlast/tvalid/tready  out x5/in  same widths, 1  kernel sink.
REQ-016 s_axis_kout_tdata/tkeep/tdest/tlast/tvalid/tready  in x5/out  same widths  kernel source.
REQ-017 m_axis_out_tdata/tkeep/tdest/tlast/tvalid/tready  out x5/in  same widths  host result stream.

Function
REQ-018 FSM states SHALL be IDLE, CFG, RESP, STREAM, DRAIN, DONE.
REQ-019 IDLE: cmd_ready=1; accepted cmd with cmd_elements=0 SHALL go to DONE with done_err=1, done_results=0, no AXI-lite write.
REQ-020 IDLE: accepted non-zero cmd SHALL latch count, clear both counters, go to CFG next cycle.
REQ-021 CFG: awvalid and wvalid asserted together (awaddr=CTRL_ADDR[4:0], wdata=count, wstrb=4'hF); each held until its own ready, independently; go to RESP once both accepted.
REQ-022 RESP: bready=1; bvalid with bresp=0 -> STREAM; bresp!=0 -> DONE with done_err=1.
REQ-023 STREAM: kin driven combinationally from in (tdata/tkeep/tdest/tvalid); s_axis_in_tready = m_axis_kin_tready; zero added latency.
REQ-024 m_axis_kin_tlast SHALL be 1 exactly on the beat where in_count == count-1; in_count increments per accepted beat.
REQ-025 After the last input beat is accepted, s_axis_in_tready SHALL be 0 and FSM goes to DRAIN; excess host beats stay un-accepted.
REQ-026 In STREAM and DRAIN, out SHALL be a combinational pass-through of kout (incl. tlast); kout_tready = out_tready; res_count increments per accepted beat.
REQ-027 Result beats accepted during STREAM SHALL be counted; an accepted kout beat with tlast=1 in DRAIN SHALL go to DONE.
REQ-028 kout tlast arriving in STREAM SHALL be forwarded, counted, and latched; entering DRAIN with it latched goes directly to DONE.
REQ-029 Outside STREAM/DRAIN all tready/tvalid outputs on stream ports SHALL be 0.
REQ-030 DONE: done_valid=1, done_results=res_count, stable until done_ready; then IDLE with done_err cleared.
REQ-031 Counters 32-bit unsigned; no wrap detection required (count <= 2^32-1).
REQ-032 cmd_ready SHALL be 0 in every state except IDLE; one job in flight.

Reset
REQ-033 ap_rst SHALL force IDLE, counters 0, done_err 0, all valid/ready outputs 0 except cmd_ready=1 on the next cycle.
REQ-034 Reset mid-job SHALL abandon the job with no done, drop any pending AXI-lite transaction, and drive no further stream beats.

Structure
REQ-035 Package corr_seq_pkg SHALL hold the state enum, CTRL_ADDR default and BRESP_OKAY constant.
REQ-036 Single module; AXI-lite write sub-FSM SHALL be inline (no sub-module).

Verification
REQ-037 cmd 10 elements, all readies 1, kernel returns 10 results -> AW/W 0x10/0x0A once, kin tlast on beat 10 only, done_results=10, done_err=0.
REQ-038 awready delayed 3 cycles, wready immediate -> W accepted first, AW 3 cycles later, single B, job completes normally.
REQ-039 cmd 0 elements -> no AXI-lite activity, done_valid next cycle with done_err=1, done_results=0.
REQ-040 bresp=2'b10 -> done_err=1, no stream beats accepted.
REQ-041 Host offers 12 beats for cmd 8, random out_tready -> exactly 8 forwarded, beats 9-12 held, result count matches kernel tlast beat.
REQ-042 ap_rst asserted after 4 of 10 input beats -> IDLE next cycle, all stream valid/ready 0, cmd_ready=1, no done_valid.
